regfile_port_sequencer: RTL and testbench



---
 rtl/regfile_port_sequencer.sv | 143 ++++++++++++++
 tb/tb_regfile_port_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_sequencer.sv
// Purpose: sole owner of the integer register file write port (WE3/A3/WD3); runs a
//          clear sweep of x1..x31 after reset or on request, then arbitrates core vs debug.
// Latency: combinational port drive in the same cycle; a clear sweep occupies 31 cycles.
// Backpressure: core is stalled during clear and on a forced debug grant; debug is
//          held off (dbg_ready_o=0) while the core owns the port, bounded by STARVE_LIMIT.
//
// Ports:
//   clk_i, rst_ni                      clock (rising edge), async active-low reset
//   clr_req_i                          one-cycle pulse requesting a full clear (ignored while clearing)
//   core_we_i/core_a_i/core_wd_i       core writeback request
//   dbg_valid_i/dbg_a_i/dbg_wd_i       debug/loader write request (held until dbg_ready_o)
//   dbg_ready_o                        debug write accepted this cycle
//   core_stall_o                       core must re-present its writeback next cycle
//   busy_o                             clear sweep in progress
//   we3_o/a3_o/wd3_o                   register file write port
module regfile_port_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     INIT_IDX     = 9,
    parameter logic [XLEN-1:0] INIT_VAL     = 'h0000_2004,
    parameter int unsigned     STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_req_i,
    input  logic            core_we_i,
    input  logic [4:0]      core_a_i,
    input  logic [XLEN-1:0] core_wd_i,
    input  logic            dbg_valid_i,
    input  logic [4:0]      dbg_a_i,
    input  logic [XLEN-1:0] dbg_wd_i,
    output logic            dbg_ready_o,
    output logic            core_stall_o,
    output logic            busy_o,
    output logic            we3_o,
    output logic [4:0]      a3_o,
    output logic [XLEN-1:0] wd3_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int unsigned      CW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]    LIMIT     = CW'(STARVE_LIMIT);
    localparam logic [4:0]       IDX_FIRST = 5'd1;
    localparam logic [4:0]       IDX_LAST  = 5'd31;
    localparam logic [4:0]       INIT_A    = 5'(INIT_IDX);

    state_e         state_q, state_d;
    logic [4:0]     clr_idx_q, clr_idx_d;
    logic [CW-1:0]  starve_q, starve_d;
    logic           forced;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= IDX_FIRST;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            starve_q  <= starve_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        starve_d     = starve_q;
        we3_o        = 1'b0;
        a3_o         = '0;
        wd3_o        = '0;
        dbg_ready_o  = 1'b0;
        core_stall_o = 1'b1;
        busy_o       = 1'b1;
        // Forced grant only makes sense with a request present; debug holds its
        // request until accepted, so in practice valid is always high here.
        forced       = dbg_valid_i && (starve_q == LIMIT);

        // Outputs are gated by the reset pin itself so they drop the moment reset
        // asserts, not at the next edge.
        if (rst_ni) begin
            case (state_q)
                ST_CLEAR: begin
                    we3_o    = 1'b1;
                    a3_o     = clr_idx_q;
                    wd3_o    = (clr_idx_q == INIT_A) ? INIT_VAL : '0;
                    starve_d = '0;
                    if (clr_idx_q == IDX_LAST) begin
                        state_d   = ST_RUN;
                        clr_idx_d = IDX_FIRST;
                    end else begin
                        clr_idx_d = clr_idx_q + 5'd1;
                    end
                end

                ST_RUN: begin
                    busy_o       = 1'b0;
                    core_stall_o = 1'b0;
                    if (forced) begin
                        // Debug has waited long enough: steal one cycle from the core.
                        we3_o        = 1'b1;
                        a3_o         = dbg_a_i;
                        wd3_o        = dbg_wd_i;
                        dbg_ready_o  = 1'b1;
                        core_stall_o = 1'b1;
                    end else if (core_we_i) begin
                        we3_o = 1'b1;
                        a3_o  = core_a_i;
                        wd3_o = core_wd_i;
                    end else if (dbg_valid_i) begin
                        we3_o       = 1'b1;
                        a3_o        = dbg_a_i;
                        wd3_o       = dbg_wd_i;
                        dbg_ready_o = 1'b1;
                    end

                    if (dbg_valid_i && !dbg_ready_o) begin
                        starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CW'(1);
                    end else begin
                        starve_d = '0;
                    end

                    // The port still follows the run rules this cycle; the sweep
                    // starts from x1 on the next one.
                    if (clr_req_i) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = IDX_FIRST;
                        starve_d  = '0;
                    end
                end

                default: begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = IDX_FIRST;
                    starve_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
module tb_regfile_port_sequencer;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        clr_req = 1'b0;
    logic        core_we = 1'b0;
    logic [4:0]  core_a = '0;
    logic [31:0] core_wd = '0;
    logic        dbg_valid = 1'b0;
    logic [4:0]  dbg_a = '0;
    logic [31:0] dbg_wd = '0;
    logic        dbg_ready, core_stall, busy, we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    regfile_port_sequencer #(
        .XLEN(32), .INIT_IDX(9), .INIT_VAL(32'h0000_2004), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_req_i(clr_req),
        .core_we_i(core_we), .core_a_i(core_a), .core_wd_i(core_wd),
        .dbg_valid_i(dbg_valid), .dbg_a_i(dbg_a), .dbg_wd_i(dbg_wd),
        .dbg_ready_o(dbg_ready), .core_stall_o(core_stall), .busy_o(busy),
        .we3_o(we3), .a3_o(a3), .wd3_o(wd3)
    );

    // Register file attached to the port; x0 is hardwired to zero.
    logic        preload = 1'b1;
    logic [31:0] env_rf [32];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) env_rf[i] <= (i == 0) ? 32'h0 : (32'hBAD0_0000 | i);
        end else if (we3 && a3 != 5'd0) begin
            env_rf[a3] <= wd3;
        end
    end

    // Reference model: m_pos = next register the clear sweep writes (0 = running),
    // m_blk = consecutive cycles debug has been refused, m_rf = expected contents.
    int          m_pos;
    int          m_blk;
    logic [31:0] m_rf [32];
    logic        m_rdy, m_stall;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pos = 1;
        m_blk = 0;
    endtask

    task automatic cycle(input string tag, input logic rst, input logic clr,
                         input logic cwe, input logic [4:0] ca, input logic [31:0] cwd,
                         input logic dv, input logic [4:0] da, input logic [31:0] dwd,
                         input bit commit);
        logic        e_we, e_rdy, e_stall, e_busy;
        logic [4:0]  e_a;
        logic [31:0] e_wd;
        @(negedge clk);
        rst_n = rst; clr_req = clr;
        core_we = cwe; core_a = ca; core_wd = cwd;
        dbg_valid = dv; dbg_a = da; dbg_wd = dwd;
        #1;
        e_we = 1'b0; e_a = '0; e_wd = '0; e_rdy = 1'b0; e_stall = 1'b1; e_busy = 1'b1;
        if (!rst) begin
            // everything parked
        end else if (m_pos != 0) begin
            e_we = 1'b1;
            e_a  = m_pos[4:0];
            e_wd = (m_pos == 9) ? 32'h0000_2004 : 32'h0;
        end else begin
            e_busy = 1'b0;
            e_stall = 1'b0;
            if (dv && m_blk >= LIMIT) begin
                e_we = 1'b1; e_a = da; e_wd = dwd; e_rdy = 1'b1; e_stall = 1'b1;
            end else if (cwe) begin
                e_we = 1'b1; e_a = ca; e_wd = cwd;
            end else if (dv) begin
                e_we = 1'b1; e_a = da; e_wd = dwd; e_rdy = 1'b1;
            end
        end
        check(tag, {busy, we3, a3, wd3, core_stall, dbg_ready},
                   {e_busy, e_we, e_a, e_wd, e_stall, e_rdy});
        m_rdy = e_rdy;
        m_stall = e_stall;
        if (commit) begin
            if (!rst) begin
                model_reset();
            end else begin
                if (e_we && e_a != 5'd0) m_rf[e_a] = e_wd;
                if (m_pos != 0) begin
                    m_pos = (m_pos == 31) ? 0 : m_pos + 1;
                    m_blk = 0;
                end else begin
                    m_blk = (dv && !e_rdy) ? ((m_blk < LIMIT) ? m_blk + 1 : LIMIT) : 0;
                    if (clr) model_reset();
                end
            end
        end
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    endtask

    initial begin
        logic        cwe_p, dv_p, clr_r;
        logic [4:0]  ca_p, da_p;
        logic [31:0] cwd_p, dwd_p;

        for (int i = 0; i < 32; i++) m_rf[i] = (i == 0) ? 32'h0 : (32'hBAD0_0000 | i);
        model_reset();

        // Reset held: port idle, core stalled, busy.
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("reset_hold%0d", i), 1'b0, 1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1);
        end
        preload = 1'b0;

        // Power-on sweep: 31 writes x1..x31, then busy falls.
        for (int i = 1; i <= 31; i++) idle($sformatf("por_clear%0d", i));
        idle("por_run");
        check("por_busy_low", {63'h0, busy}, 64'h0);
        check("por_x9", {32'h0, env_rf[9]}, 64'h2004);
        check("por_x5", {32'h0, env_rf[5]}, 64'h0);

        // Core writeback alone.
        cycle("core_wr", 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b1);
        // Debug write alone, then read back.
        cycle("dbg_wr", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b1);
        idle("dbg_wr_after");
        check("dbg_x7", {32'h0, env_rf[7]}, 64'h1234);
        check("core_x5", {32'h0, env_rf[5]}, 64'hDEAD_BEEF);

        // Debug write to x0 is accepted; the file masks it.
        cycle("dbg_x0", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h7777, 1'b1);
        idle("dbg_x0_after");
        check("x0_zero", {32'h0, env_rf[0]}, 64'h0);

        // Starvation: four refusals, forced grant on the 5th, core back on the 6th.
        for (int i = 1; i <= 4; i++) begin
            cycle($sformatf("starve%0d", i), 1'b1, 1'b0, 1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd12, 32'h5555, 1'b1);
        end
        cycle("starve_force", 1'b1, 1'b0, 1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd12, 32'h5555, 1'b1);
        check("force_port", {55'h0, core_stall, dbg_ready, we3, a3, 1'b0},
                            {55'h0, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0});
        cycle("starve_after", 1'b1, 1'b0, 1'b1, 5'd10, 32'hAAAA, 1'b0, 5'd0, 32'h0, 1'b1);
        check("after_core", {56'h0, core_stall, dbg_ready, a3, 1'b0}, {56'h0, 1'b0, 1'b0, 5'd10, 1'b0});

        // Requested clear with a second request mid-sweep.
        cycle("x3_wr", 1'b1, 1'b0, 1'b1, 5'd3, 32'hFF, 1'b0, 5'd0, 32'h0, 1'b1);
        cycle("clr_pulse", 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 1; i <= 31; i++) begin
            cycle($sformatf("req_clear%0d", i), 1'b1, (i == 10), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        end
        idle("req_run");
        check("req_busy_low", {63'h0, busy}, 64'h0);
        check("req_x3", {32'h0, env_rf[3]}, 64'h0);
        check("req_x9", {32'h0, env_rf[9]}, 64'h2004);

        // Randomised traffic; core re-presents when stalled, debug holds until accepted.
        cwe_p = 1'b0; ca_p = '0; cwd_p = '0;
        dv_p = 1'b0; da_p = '0; dwd_p = '0;
        m_stall = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(cwe_p && m_stall)) begin
                cwe_p = ($urandom_range(0, 3) != 0);
                ca_p  = 5'($urandom);
                cwd_p = $urandom;
            end
            if (!dv_p && $urandom_range(0, 2) == 0) begin
                dv_p  = 1'b1;
                da_p  = 5'($urandom);
                dwd_p = $urandom;
            end
            clr_r = ($urandom_range(0, 63) == 0);
            cycle($sformatf("rand%0d", i), 1'b1, clr_r, cwe_p, ca_p, cwd_p, dv_p, da_p, dwd_p, 1'b1);
            if (m_rdy) dv_p = 1'b0;
        end
        // Drain any sweep or pending debug request, then a write-free cycle.
        for (int i = 0; i < 34; i++) begin
            cycle($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, dv_p, da_p, dwd_p, 1'b1);
            if (m_rdy) dv_p = 1'b0;
        end
        idle("drain_quiet");
        for (int i = 0; i < 32; i++) begin
            check($sformatf("rand_x%0d", i), {32'h0, env_rf[i]}, {32'h0, m_rf[i]});
        end

        // Reset asserted between edges in the 10th sweep cycle.
        cycle("clr_pulse2", 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 1; i <= 9; i++) idle($sformatf("pre_rst_clear%0d", i));
        cycle("rst_cycle10", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", {20'h0, we3, core_stall, busy, dbg_ready, a3, wd3, 2'b0},
                               {20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 2'b0});
        model_reset();
        cycle("rst_low", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 1; i <= 31; i++) idle($sformatf("post_rst_clear%0d", i));
        idle("post_rst_run");
        check("post_rst_x9", {32'h0, env_rf[9]}, 64'h2004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
